// File: rtl/aes_ct_uart_tx.sv
// rtl/aes_ct_uart_tx.sv - ciphertext-to-UART hex streamer
// Captures the 128-bit ct on a valid rising edge and sends it as 32 ASCII hex chars (+CR LF).
module aes_ct_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] ct,
  input  logic         valid,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]      LAST_CHAR = APPEND_CRLF ? 6'd33 : 6'd31;
  localparam logic            SB_LAST   = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic           sb_q, sb_d;
  logic [5:0]     char_q, char_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [127:0]   buf_q, buf_d;
  logic           valid_q;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;

  logic rise, msg_active, cnt_wrap;

  function automatic logic [7:0] hex_char(input logic [127:0] b, input logic [5:0] idx);
    logic [127:0] sh;
    logic [3:0]   nib;
    sh  = b << {idx, 2'b00};
    nib = sh[127:124];
    if (idx == 6'd32)      hex_char = 8'h0D;
    else if (idx == 6'd33) hex_char = 8'h0A;
    else if (nib < 4'd10)  hex_char = 8'h30 + {4'h0, nib};
    else                   hex_char = 8'h37 + {4'h0, nib};
  endfunction

  assign rise       = valid & ~valid_q;
  // The done cycle still belongs to the finishing message, so an edge there is an overrun.
  assign msg_active = (state_q != IDLE) || done_q;
  assign cnt_wrap   = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sb_d      = sb_q;
    char_d    = char_q;
    shreg_d   = shreg_q;
    buf_d     = buf_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (rise & msg_active);

    unique case (state_q)
      IDLE: begin
        if (rise && !done_q) begin
          buf_d   = ct;
          shreg_d = hex_char(ct, 6'd0);
          char_d  = 6'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            sb_d    = 1'b0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (sb_q == SB_LAST) begin
            if (char_q == LAST_CHAR) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              char_d  = char_q + 6'd1;
              shreg_d = hex_char(buf_q, char_q + 6'd1);
              tx_d    = 1'b0;
              state_d = START;
            end
          end else begin
            sb_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      sb_q      <= 1'b0;
      char_q    <= 6'd0;
      shreg_q   <= 8'h00;
      buf_q     <= '0;
      valid_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sb_q      <= sb_d;
      char_q    <= char_d;
      shreg_q   <= shreg_d;
      buf_q     <= buf_d;
      valid_q   <= valid;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
